// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared CNN definitions: sample width and signed sample type used by the
// ReLU, max-pool and inter-layer buffer blocks.
package maxpool_2x2_stream_pkg;

   localparam int DATA_WIDTH = 26;

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/maxpool_2x2_stream_pool_line_buf.sv
// pool_line_buf: half-row buffer of horizontal maxima.
// Single-port RAM, synchronous write, combinational read (distributed RAM).
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address (pair index within the row)
//   wdata : sample to store
//   rdata : sample at addr, combinational
module pool_line_buf
   import maxpool_2x2_stream_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int ADDR_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  sample_t           wdata,
   output sample_t           rdata
);

   sample_t mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster-order signed sample stream.
//   clk, rst   : clock, async active-high reset
//   start      : arm / restart a frame
//   in_valid   : sample valid (accepted only while running)
//   in_data    : signed sample
//   out_valid  : one-cycle strobe per pooled value
//   out_data   : pooled maximum, held until the next output
//   busy       : high while running
//   frame_done : one-cycle pulse with the last out_valid of a frame
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for start, in_valid ignored
// RUN   | accepting pixels until (ROWS-1, depth-1)
module maxpool_2x2_stream
   import maxpool_2x2_stream_pkg::*;
#(
   parameter int depth = 128,
   parameter int ROWS  = 128
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    start,
   input  logic    in_valid,
   input  sample_t in_data,
   output logic    out_valid,
   output sample_t out_data,
   output logic    busy,
   output logic    frame_done
);

   localparam int CW = $clog2(depth);
   localparam int RW = $clog2(ROWS);
   localparam int AW = (CW > 1) ? CW - 1 : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(depth - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   sample_t       h_reg, hmax, lb_rdata, pool;
   logic          frame_last, accept, emit, lb_we;
   logic [AW-1:0] lb_addr;

   assign frame_last = (col == COL_LAST) && (row == ROW_LAST);
   // start drops a coincident pixel, except the frame's final pixel,
   // which still completes the frame.
   assign accept  = (state == S_RUN) && in_valid && (!start || frame_last);
   assign emit    = accept && col[0] && row[0];
   assign lb_we   = accept && col[0] && !row[0];
   assign lb_addr = AW'(col >> 1);
   assign hmax    = (in_data > h_reg) ? in_data : h_reg;
   assign pool    = (lb_rdata > hmax) ? lb_rdata : hmax;
   assign busy    = (state == S_RUN);

   pool_line_buf #(
      .ENTRIES (depth / 2),
      .ADDR_W  (AW)
   ) u_line_buf (
      .clk   (clk),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (hmax),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (!start && accept && frame_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col   <= '0;
         row   <= '0;
         h_reg <= '0;
      end else if (start) begin
         col   <= '0;
         row   <= '0;
         h_reg <= '0;
      end else if (accept) begin
         if (!col[0]) h_reg <= in_data;
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_data   <= '0;
      end else begin
         out_valid  <= emit;
         frame_done <= accept && frame_last;
         if (emit) out_data <= pool;
      end
   end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
module tb_maxpool_2x2_stream;
   import maxpool_2x2_stream_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic    s_start, s_valid, s_ov, s_busy, s_fd;
   sample_t s_data, s_od;
   logic    l_start, l_valid, l_ov, l_busy, l_fd;
   sample_t l_data, l_od;

   maxpool_2x2_stream #(.depth(4), .ROWS(4)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
      .out_valid(s_ov), .out_data(s_od), .busy(s_busy), .frame_done(s_fd)
   );

   maxpool_2x2_stream #(.depth(128), .ROWS(128)) dut_l (
      .clk(clk), .rst(rst), .start(l_start), .in_valid(l_valid), .in_data(l_data),
      .out_valid(l_ov), .out_data(l_od), .busy(l_busy), .frame_done(l_fd)
   );

   typedef struct {
      sample_t d;
      logic    last;
      int      cyc;
   } exp_t;

   exp_t    q_s[$];
   exp_t    q_l[$];
   int      cyc = 0;
   int      total = 0;
   int      passed = 0;
   int      n_ov_s = 0, n_fd_s = 0, n_ov_l = 0, n_fd_l = 0;
   sample_t pix_s [16];
   sample_t pix_l [16384];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic sample_t max4(input sample_t a, input sample_t b,
                                    input sample_t c, input sample_t d);
      sample_t m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Scoreboard monitors, sampling on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (s_ov === 1'b1) begin
         n_ov_s++;
         if (s_fd === 1'b1) n_fd_s++;
         check("s_out_expected", q_s.size() > 0, 1);
         if (q_s.size() > 0) begin
            e = q_s.pop_front();
            check("s_out_data", s_od, e.d);
            check("s_frame_done", s_fd, e.last);
            check("s_latency_cycle", cyc, e.cyc);
         end
      end else if (s_fd !== 1'b0) begin
         n_fd_s++;
         check("s_frame_done_alone", s_fd, 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (l_ov === 1'b1) begin
         n_ov_l++;
         if (l_fd === 1'b1) n_fd_l++;
         check("l_out_expected", q_l.size() > 0, 1);
         if (q_l.size() > 0) begin
            e = q_l.pop_front();
            check("l_out_data", l_od, e.d);
            check("l_frame_done", l_fd, e.last);
            check("l_latency_cycle", cyc, e.cyc);
         end
      end else if (l_fd !== 1'b0) begin
         n_fd_l++;
         check("l_frame_done_alone", l_fd, 0);
      end
   end

   // Each step is entered 1 time unit after a rising edge and ends there.
   task automatic step_s(input logic v, input sample_t d, input logic st);
      s_valid = v; s_data = d; s_start = st;
      @(posedge clk); #1;
      s_valid = 1'b0; s_start = 1'b0;
   endtask

   task automatic step_l(input logic v, input sample_t d, input logic st);
      l_valid = v; l_data = d; l_start = st;
      @(posedge clk); #1;
      l_valid = 1'b0; l_start = 1'b0;
   endtask

   task automatic frame_s(input int gap, input logic start_on_last);
      exp_t e;
      for (int idx = 0; idx < 16; idx++) begin
         if (((idx / 4) % 2 == 1) && ((idx % 4) % 2 == 1)) begin
            e.d    = max4(pix_s[idx-5], pix_s[idx-4], pix_s[idx-1], pix_s[idx]);
            e.last = (idx == 15);
            e.cyc  = cyc + 1;
            q_s.push_back(e);
         end
         step_s(1'b1, pix_s[idx], start_on_last && (idx == 15));
         if (idx != 15) repeat (gap) step_s(1'b0, '0, 1'b0);
      end
   endtask

   task automatic ramp_s();
      for (int i = 0; i < 16; i++) pix_s[i] = sample_t'(i);
   endtask

   task automatic drain_s(input string tag);
      repeat (4) step_s(1'b0, '0, 1'b0);
      check(tag, q_s.size(), 0);
   endtask

   initial begin
      int ov0, fd0;
      exp_t e;
      rst = 1'b1;
      s_start = 1'b0; s_valid = 1'b0; s_data = '0;
      l_start = 1'b0; l_valid = 1'b0; l_data = '0;
      #12;
      check("rst_out_valid", s_ov, 0);
      check("rst_frame_done", s_fd, 0);
      check("rst_busy", s_busy, 0);
      check("rst_out_data", s_od, 0);
      check("rst_l_busy", l_busy, 0);
      check("rst_l_out_valid", l_ov, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: ramp
      ramp_s();
      step_s(1'b0, '0, 1'b1);
      check("t1_busy_after_start", s_busy, 1);
      frame_s(0, 1'b0);
      check("t1_busy_after_last", s_busy, 0);
      drain_s("t1_queue_empty");

      // 2: signed windows and an all -5 frame
      for (int i = 0; i < 16; i++) pix_s[i] = sample_t'(-3 * i);
      pix_s[0] = -1;  pix_s[1] = -100; pix_s[4] = -7; pix_s[5] = -3;
      pix_s[2] = sample_t'(26'sh1FFFFFF); pix_s[3] = sample_t'(26'sh2000000);
      pix_s[6] = 0;   pix_s[7] = 0;
      step_s(1'b0, '0, 1'b1);
      frame_s(0, 1'b0);
      for (int i = 0; i < 16; i++) pix_s[i] = -5;
      step_s(1'b0, '0, 1'b1);
      frame_s(0, 1'b0);
      drain_s("t2_queue_empty");

      // 3: gapped ramp
      ov0 = n_ov_s; fd0 = n_fd_s;
      ramp_s();
      step_s(1'b0, '0, 1'b1);
      frame_s(2, 1'b0);
      drain_s("t3_queue_empty");
      check("t3_out_valid_count", n_ov_s - ov0, 4);
      check("t3_frame_done_count", n_fd_s - fd0, 1);

      // 4: idle pixels ignored, restart mid-frame drops coincident pixel
      for (int i = 0; i < 8; i++) step_s(1'b1, sample_t'(1000 + i), 1'b0);
      check("t4_busy_idle", s_busy, 0);
      step_s(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step_s(1'b1, sample_t'(1000 + i), 1'b0);
      step_s(1'b1, sample_t'(1005), 1'b1);
      check("t4_busy_restart", s_busy, 1);
      frame_s(0, 1'b0);
      drain_s("t4_queue_empty");

      // 4b: start coincident with final pixel
      step_s(1'b0, '0, 1'b1);
      frame_s(0, 1'b1);
      check("t4b_busy_stays", s_busy, 1);
      frame_s(0, 1'b0);
      check("t4b_busy_end", s_busy, 0);
      drain_s("t4b_queue_empty");

      // 5: async reset with an output pending on the bus
      step_s(1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) step_s(1'b1, sample_t'(i), 1'b0);
      check("t5_pre_out_valid", s_ov, 1);
      check("t5_pre_out_data", s_od, 5);
      rst = 1'b1;
      #1;
      check("t5_rst_out_valid", s_ov, 0);
      check("t5_rst_frame_done", s_fd, 0);
      check("t5_rst_busy", s_busy, 0);
      check("t5_rst_out_data", s_od, 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      ramp_s();
      step_s(1'b0, '0, 1'b1);
      frame_s(0, 1'b0);
      drain_s("t5_queue_empty");

      // 6: full-size random frame with random bubbles
      for (int i = 0; i < 16384; i++) pix_l[i] = sample_t'($urandom);
      ov0 = n_ov_l; fd0 = n_fd_l;
      step_l(1'b0, '0, 1'b1);
      for (int idx = 0; idx < 16384; idx++) begin
         if (((idx / 128) % 2 == 1) && ((idx % 128) % 2 == 1)) begin
            e.d    = max4(pix_l[idx-129], pix_l[idx-128], pix_l[idx-1], pix_l[idx]);
            e.last = (idx == 16383);
            e.cyc  = cyc + 1;
            q_l.push_back(e);
         end
         step_l(1'b1, pix_l[idx], 1'b0);
         if ($urandom_range(0, 2) == 0) step_l(1'b0, '0, 1'b0);
      end
      check("t6_busy_end", l_busy, 0);
      repeat (4) step_l(1'b0, '0, 1'b0);
      check("t6_queue_empty", q_l.size(), 0);
      check("t6_out_valid_count", n_ov_l - ov0, 4096);
      check("t6_frame_done_count", n_fd_l - fd0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
